// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared constants, types and helpers for the rv32i fetch path
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC        = 32'd4;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic {
        REQ_IDLE,
        REQ_WAIT
    } req_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/rv32i_fetch_queue_if.sv
// rtl/rv32i_fetch_queue_if.sv - instruction bus, decode output and redirect signals of the fetch queue
interface rv32i_fetch_queue_if;
    import rv32i_pkg::*;

    logic [XLEN-1:0] o_iaddr;
    logic            o_stb_inst;
    logic            i_ack_inst;
    logic [XLEN-1:0] i_inst;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_inst;
    logic            o_ce;
    logic            i_stall;
    logic            i_flush;
    logic            i_alu_change_pc;
    logic [XLEN-1:0] i_alu_next_pc;
    logic            i_writeback_change_pc;
    logic [XLEN-1:0] i_writeback_next_pc;

    modport master (
        output o_iaddr, o_stb_inst, o_pc, o_inst, o_ce,
        input  i_ack_inst, i_inst, i_stall, i_flush,
               i_alu_change_pc, i_alu_next_pc,
               i_writeback_change_pc, i_writeback_next_pc
    );

    modport slave (
        input  o_iaddr, o_stb_inst, o_pc, o_inst, o_ce,
        output i_ack_inst, i_inst, i_stall, i_flush,
               i_alu_change_pc, i_alu_next_pc,
               i_writeback_change_pc, i_writeback_next_pc
    );

endinterface

// File: rtl/rv32i_fetch_fifo.sv
// rtl/rv32i_fetch_fifo.sv - synchronous FIFO of {pc, inst} pairs with clear and occupancy count
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    push,
    input  fetch_entry_t            wdata,
    input  logic                    pop,
    output fetch_entry_t            rdata,
    input  logic                    clear,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rv32i_fetch_queue.sv
// rtl/rv32i_fetch_queue.sv - fetch stage with single outstanding bus request and a {pc, inst} queue
module rv32i_fetch_queue
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET    = 32'h0000_0000,
    parameter int              QUEUE_DEPTH = 4
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    rv32i_fetch_queue_if.master bus
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

    req_state_t      state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] iaddr;
    logic            stb;
    logic            discard;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic            ce;

    logic            kill;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic            ack;
    logic            push;
    logic            pop;
    logic            space;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic [CW:0]     count_next;
    fetch_entry_t    head;
    fetch_entry_t    wentry;

    assign kill   = bus.i_flush | bus.i_alu_change_pc | bus.i_writeback_change_pc;
    assign target = bus.i_writeback_change_pc ? align_pc(bus.i_writeback_next_pc) :
                    bus.i_alu_change_pc       ? align_pc(bus.i_alu_next_pc)       : fetch_pc;

    // An ack only counts while a request is actually on the bus.
    assign ack        = stb & bus.i_ack_inst;
    assign push       = ack & ~discard & ~kill & (~full | pop);
    assign pop        = ~kill & ~bus.i_stall & ~empty;
    assign next_pc    = kill ? target : (push ? fetch_pc + PC_INC : fetch_pc);
    assign count_next = kill ? '0 : {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign space      = count_next < DEPTH_W;
    assign wentry     = '{pc: iaddr, inst: bus.i_inst};

    rv32i_fetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .wdata   (wentry),
        .pop     (pop),
        .rdata   (head),
        .clear   (kill),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= REQ_IDLE;
            fetch_pc <= PC_RESET;
            iaddr    <= PC_RESET;
            stb      <= 1'b0;
            discard  <= 1'b0;
        end else begin
            fetch_pc <= next_pc;
            case (state)
                REQ_IDLE: begin
                    if (space) begin
                        state <= REQ_WAIT;
                        stb   <= 1'b1;
                        iaddr <= next_pc;
                    end
                end
                REQ_WAIT: begin
                    if (ack) begin
                        discard <= 1'b0;
                        if (space) begin
                            iaddr <= next_pc;
                        end else begin
                            state <= REQ_IDLE;
                            stb   <= 1'b0;
                        end
                    end else if (kill) begin
                        // Request stays on the bus; its reply is stale and must be dropped.
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state <= REQ_IDLE;
                    stb   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ce     <= 1'b0;
            pc_q   <= '0;
            inst_q <= '0;
        end else if (kill) begin
            ce <= 1'b0;
        end else if (!bus.i_stall) begin
            ce <= ~empty;
            if (!empty) begin
                pc_q   <= head.pc;
                inst_q <= head.inst;
            end
        end
    end

    assign bus.o_iaddr    = iaddr;
    assign bus.o_stb_inst = stb;
    assign bus.o_pc       = pc_q;
    assign bus.o_inst     = inst_q;
    assign bus.o_ce       = ce;

endmodule

// File: doc/rv32i_fetch_queue.md
# rv32i_fetch_queue

Parametrised successor to the single-entry fetch stage of the rv32i core. It decouples instruction-memory latency from decode by buffering fetched {pc, instruction} pairs in a FIFO of configurable depth. It keeps a single outstanding stb/ack request and handles redirects from ALU and writeback by discarding stale data. It sits between the instruction bus and the decode stage, and presents a registered {o_pc, o_inst, o_ce} to decode.

## Interface
- PC_RESET, 32'h0000_0000, first fetch address after reset
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- o_iaddr  out  32  instruction address; bits [1:0] always 0
- o_stb_inst  out  1  request strobe, held with o_iaddr until ack
- i_ack_inst  in  1  request complete; i_inst valid this cycle
- i_inst  in  32  fetched instruction
- o_pc  out  32  PC of instruction presented to decode
- o_inst  out  32  instruction presented to decode
- o_ce  out  1  o_pc/o_inst valid (clock-enable to decode)
- i_stall  in  1  decode cannot accept; hold output register
- i_flush  in  1  kill queue and output register, PC unchanged
- i_alu_change_pc  in  1  branch/jump redirect
- i_alu_next_pc  in  32  branch target
- i_writeback_change_pc  in  1  trap/mret redirect; priority over ALU
- i_writeback_next_pc  in  32  trap target

## Operation
- Reset values: fetch PC = PC_RESET, o_iaddr = PC_RESET, o_stb_inst = 0, o_ce = 0, o_pc = 0, o_inst = 0, queue empty, discard flag = 0.
- Request FSM, two states:
  - IDLE: assert stb next cycle when free slots ≥ 1, computed as count after this cycle's push/pop < QUEUE_DEPTH.
  - WAIT: stb = 1 with o_iaddr stable until i_ack_inst.
- On ack with discard = 0: push {o_iaddr, i_inst}; fetch PC += 4 (32-bit wrap, no flag).
- Stay in WAIT back-to-back (new o_iaddr next cycle) if space remains; otherwise go to IDLE.
- Redirect (writeback > ALU): fetch PC ← target & ~3; queue cleared; o_ce ← 0.
  - In WAIT without ack: set discard and keep stb/o_iaddr until ack. The discarded ack is not pushed; the next request uses the target.
  - Ack in the same cycle as the redirect: data dropped; next-cycle request to the target.
- i_flush: same as a redirect but fetch PC is unchanged. Coincident redirect wins (target used).
- Output register:
  - When !i_stall: load queue head and pop if non-empty (o_ce ← 1), else o_ce ← 0.
  - When i_stall: hold all outputs and do not pop.
  - Redirect/flush forces o_ce ← 0 regardless of i_stall.
- Push and pop in the same cycle when full or empty: both legal, count unchanged. Pop from an empty queue never occurs.
- Reset assertion mid-request: immediate return to reset state. A bus ack arriving after reset release while stb = 0 is ignored.

## Timing
- Ack in cycle n (combinational memory) → entry in queue at n+1 → o_ce = 1 at n+2. Minimum latency from the first stb is 2 cycles.
- Steady state with ack every cycle and no stall: one instruction per cycle on o_ce.
- First stb appears in the first cycle after rst_n deasserts.
- Redirect in cycle r with no pending request: stb with o_iaddr = target at r+1, first o_ce for the target at r+3 with zero-wait ack.

## Structure
- Shared package rv32i_pkg: XLEN = 32, PC_INC = 4, PC alignment mask, request FSM state enum.
- Sub-module rv32i_fetch_fifo: parametrised synchronous FIFO carrying {pc, inst}. It provides push, pop, clear, full, empty, and a count of width $clog2(QUEUE_DEPTH)+1.
- Top level holds the request FSM, PC register, discard flag, and output register.

## Test plan
- Reset, ack tied high, imem words 0x13, 0x00100093, 0x00200113…: o_iaddr 0, 4, 8… on consecutive cycles; o_ce first at cycle 3 with o_pc = 0; then o_pc increments by 4 each cycle.
- ack low for 4 cycles, then high: o_iaddr and stb held constant; o_ce drops after queue drains; no duplicated or skipped PC.
- i_stall high 4 cycles, QUEUE_DEPTH = 4: output held; queue fills to 4 and stb deasserts; on release, PCs continue in order with no loss.
- ALU redirect to 16 while a request is pending and ack is delayed 2 cycles: stale data dropped; next o_iaddr = 16; next o_ce shows o_pc = 16.
- Writeback (32) and ALU (16) redirects in the same cycle, coincident with an ack: o_iaddr = 32 next cycle; acked data never reaches o_ce.
- i_flush pulse at fetch PC 0x28: o_ce = 0 next cycle; refetch resumes at 0x28; misaligned target 0x13 produces o_iaddr 0x10.
